// File: rtl/convert_arb.sv
// convert_arb: round-robin arbiter in front of a shared two-stage fixed-point
// format converter. Each requester offers one signed sample in format
// (N_BITS_IN, BIN_PT_IN). The granted sample is realigned to BIN_PT_OUT with
// round-half-up, then saturated to N_BITS_OUT bits. Results are tagged with the
// index of the requester that sent them.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_data    packed samples; requester i at [i*N_BITS_IN +: N_BITS_IN]
//   in_valid   per-requester valid
//   in_ready   per-requester ready; at most one bit is high
//   out_data   converted sample
//   out_id     index of the originating requester
//   out_ovf    high when the sample was saturated
//   out_valid  result valid
//   out_ready  consumer ready
module convert_arb #(
  parameter int N_REQ      = 4,
  parameter int N_BITS_IN  = 8,
  parameter int BIN_PT_IN  = 4,
  parameter int N_BITS_OUT = 4,
  parameter int BIN_PT_OUT = 1,
  parameter int ID_W       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ*N_BITS_IN-1:0]   in_data,
  input  logic [N_REQ-1:0]             in_valid,
  output logic [N_REQ-1:0]             in_ready,
  output logic [N_BITS_OUT-1:0]        out_data,
  output logic [ID_W-1:0]              out_id,
  output logic                         out_ovf,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int D  = BIN_PT_IN - BIN_PT_OUT;
  localparam int AD = (D > 0) ? D : -D;
  // One guard bit on top of the alignment shift so neither the rounding
  // addition nor the left shift can overflow.
  localparam int W1 = N_BITS_IN + AD + 1;

  localparam logic signed [W1-1:0] SAT_MAX = W1'((2 ** (N_BITS_OUT - 1)) - 1);
  localparam logic signed [W1-1:0] SAT_MIN = ~SAT_MAX;

  // Pipeline and arbitration state
  logic [ID_W-1:0]        ptr_reg;
  logic                   s1_valid_reg;
  logic signed [W1-1:0]   s1_val_reg;
  logic [ID_W-1:0]        s1_id_reg;
  logic                   s2_valid_reg;
  logic [N_BITS_OUT-1:0]  s2_data_reg;
  logic                   s2_ovf_reg;
  logic [ID_W-1:0]        s2_id_reg;

  logic                   s1_adv;
  logic                   s2_adv;
  logic                   take;
  logic                   gnt_found;
  logic [ID_W-1:0]        gnt_idx;
  logic [ID_W:0]          rr_idx;
  logic [ID_W-1:0]        ptr_next;

  logic [N_BITS_IN-1:0]   lane [N_REQ];
  logic [N_BITS_IN-1:0]   sel_data;
  logic signed [W1-1:0]   ext;
  logic signed [W1-1:0]   aligned;
  logic [N_BITS_OUT-1:0]  sat_data;
  logic                   sat_ovf;

  assign s2_adv = !s2_valid_reg || out_ready;
  assign s1_adv = !s1_valid_reg || s2_adv;

  // Round-robin search starting at ptr; the sum is one bit wider than the
  // index so the wrap can be done with a single conditional subtract.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (rr_idx >= (ID_W+1)'(N_REQ)) begin
        rr_idx = rr_idx - (ID_W+1)'(N_REQ);
      end
      if (!gnt_found && in_valid[rr_idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx[ID_W-1:0];
      end
    end
  end

  // rst gates acceptance so in_ready is zero for as long as reset is held.
  assign take     = gnt_found && s1_adv && !rst;
  assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane[gi]     = in_data[gi*N_BITS_IN +: N_BITS_IN];
      assign in_ready[gi] = take && (gnt_idx == ID_W'(gi));
    end
  endgenerate

  assign sel_data = lane[gnt_idx];
  assign ext      = {{(AD+1){sel_data[N_BITS_IN-1]}}, sel_data};

  generate
    if (D > 0) begin : g_round
      // Adding half an output LSB before the floor shift rounds ties toward +inf.
      localparam logic signed [W1-1:0] HALF = W1'(2 ** (D - 1));
      assign aligned = (ext + HALF) >>> D;
    end else begin : g_widen
      assign aligned = ext <<< AD;
    end
  endgenerate

  always_comb begin
    sat_data = s1_val_reg[N_BITS_OUT-1:0];
    sat_ovf  = 1'b0;
    if (s1_val_reg > SAT_MAX) begin
      sat_data = SAT_MAX[N_BITS_OUT-1:0];
      sat_ovf  = 1'b1;
    end else if (s1_val_reg < SAT_MIN) begin
      sat_data = SAT_MIN[N_BITS_OUT-1:0];
      sat_ovf  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_val_reg   <= '0;
      s1_id_reg    <= '0;
    end else begin
      if (take) begin
        ptr_reg <= ptr_next;
      end
      if (s1_adv) begin
        s1_valid_reg <= take;
        if (take) begin
          s1_val_reg <= aligned;
          s1_id_reg  <= gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_ovf_reg   <= 1'b0;
      s2_id_reg    <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg <= sat_data;
        s2_ovf_reg  <= sat_ovf;
        s2_id_reg   <= s1_id_reg;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_data  = s2_data_reg;
  assign out_ovf   = s2_ovf_reg;
  assign out_id    = s2_id_reg;

endmodule

// File: tb/tb_convert_arb.sv
// Self-checking bench for convert_arb with default parameters
// (Q4.4 in, Q3.1 out, four requesters). Table-driven conversion vectors plus
// hand-written sequences for round-robin, backpressure and mid-stream reset.
module tb_convert_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  typedef struct {
    logic [7:0] din;
    logic [3:0] dout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic [1:0] id;
    logic       ovf;
  } rx_t;

  vec_t vecs[14];
  rx_t  rx_q[$];
  logic [7:0] bp_in[6];
  logic [3:0] bp_exp[6];

  convert_arb dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1: sample handshakes at +2, then advance one clock.
  task automatic step();
    rx_t r;
    #1;
    if ((in_valid & in_ready) != 4'b0) acc_cnt++;
    if (out_valid && out_ready) begin
      r.data = out_data;
      r.id   = out_id;
      r.ovf  = out_ovf;
      rx_q.push_back(r);
      $display("out id=%0d data=%h ovf=%b", out_id, out_data, out_ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Q4.4 -> Q3.1: out = floor((v + 4) / 8), saturated to [-8, 7]
    vecs[0]  = '{8'h16, 4'b0011, 1'b0};
    vecs[1]  = '{8'hFC, 4'b0000, 1'b0};
    vecs[2]  = '{8'h0C, 4'b0010, 1'b0};
    vecs[3]  = '{8'h7F, 4'b0111, 1'b1};
    vecs[4]  = '{8'h80, 4'b1000, 1'b1};
    vecs[5]  = '{8'h30, 4'b0110, 1'b0};
    vecs[6]  = '{8'hF4, 4'b1111, 1'b0};
    vecs[7]  = '{8'h3C, 4'b0111, 1'b1};
    vecs[8]  = '{8'h3B, 4'b0111, 1'b0};
    vecs[9]  = '{8'hC4, 4'b1001, 1'b0};
    vecs[10] = '{8'hC3, 4'b1000, 1'b0};
    vecs[11] = '{8'hBC, 4'b1000, 1'b0};
    vecs[12] = '{8'hBB, 4'b1000, 1'b1};
    vecs[13] = '{8'h00, 4'b0000, 1'b0};
    bp_in  = '{8'h10, 8'h20, 8'h30, 8'h08, 8'h18, 8'hF0};
    bp_exp = '{4'h2, 4'h4, 4'h6, 4'h1, 4'h3, 4'hE};

    // Reset state, with all requesters asking
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_id", 32'(out_id), 32'h0);
    check("rst_out_ovf", 32'(out_ovf), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 4'h0;

    // Conversion table, rotating through requesters
    for (int i = 0; i < 14; i++) begin
      int r;
      r = i % 4;
      in_data = '0;
      in_data[r*8 +: 8] = vecs[i].din;
      in_valid = 4'(1 << r);
      #1;
      check("vec_in_ready", 32'(in_ready), 32'(1 << r));
      @(posedge clk);
      #1;
      in_valid = 4'h0;
      @(posedge clk);
      #1;
      $display("vec %0d: in=%h out=%h ovf=%b id=%0d", i, vecs[i].din, out_data, out_ovf, out_id);
      check("vec_out_valid", 32'(out_valid), 32'h1);
      check("vec_out_data", 32'(out_data), 32'(vecs[i].dout));
      check("vec_out_ovf", 32'(out_ovf), 32'(vecs[i].ovf));
      check("vec_out_id", 32'(out_id), 32'(r));
      @(posedge clk);
      #1;
      check("vec_drained", 32'(out_valid), 32'h0);
    end

    // Round-robin with all requesters continuously valid
    pulse_reset();
    in_data  = {8'h30, 8'h20, 8'h10, 8'h00};
    in_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("rr_grant", 32'(in_ready), 32'(1 << (k % 4)));
      check("rr_onehot", 32'($countones(in_ready)), 32'h1);
      if (k == 1) check("rr_fill", 32'(out_valid), 32'h0);
      if (k >= 2) begin
        $display("rr cycle %0d: out id=%0d data=%h", k, out_id, out_data);
        check("rr_out_valid", 32'(out_valid), 32'h1);
        check("rr_out_id", 32'(out_id), 32'((k - 2) % 4));
        check("rr_out_data", 32'(out_data), 32'(2 * ((k - 2) % 4)));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 4'h0;
    for (int k = 0; k < 3; k++) step();

    // Backpressure on requester 2
    pulse_reset();
    rx_q.delete();
    acc_cnt = 0;
    out_ready = 1'b0;
    in_data = '0;
    for (int s = 1; s <= 5; s++) begin
      in_data[23:16] = bp_in[acc_cnt];
      in_valid = 4'b0100;
      step();
      if (s >= 2) begin
        check("bp_hold_valid", 32'(out_valid), 32'h1);
        check("bp_hold_data", 32'(out_data), 32'(bp_exp[0]));
        check("bp_hold_id", 32'(out_id), 32'h2);
      end
    end
    check("bp_buffered", 32'(acc_cnt), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    for (int s = 0; s < 40; s++) begin
      if (acc_cnt < 6) begin
        in_data[23:16] = bp_in[acc_cnt];
        in_valid = 4'b0100;
      end else begin
        in_valid = 4'h0;
      end
      if (acc_cnt >= 6 && rx_q.size() >= 6) break;
      step();
    end
    check("bp_rx_count", 32'(rx_q.size()), 32'd6);
    for (int j = 0; j < 6 && j < rx_q.size(); j++) begin
      check("bp_rx_data", 32'(rx_q[j].data), 32'(bp_exp[j]));
      check("bp_rx_id", 32'(rx_q[j].id), 32'h2);
    end

    // Reset asserted with both stages full
    pulse_reset();
    in_data  = {8'h30, 8'h20, 8'h10, 8'h00};
    in_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("mr_pre_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'h0);
    check("mr_in_ready", 32'(in_ready), 32'h0);
    check("mr_out_data", 32'(out_data), 32'h0);
    @(posedge clk);
    #1;
    rx_q.delete();
    rst = 1'b0;
    in_valid = 4'b1010;
    #1;
    check("mr_first_grant", 32'(in_ready), 32'b0010);
    @(posedge clk);
    #1;
    in_valid = 4'h0;
    for (int k = 0; k < 4; k++) step();
    check("mr_rx_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) begin
      check("mr_rx_id", 32'(rx_q[0].id), 32'h1);
      check("mr_rx_data", 32'(rx_q[0].data), 32'h2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/convert_arb.md
Name: convert_arb

Overview:
- Shares one pipelined fixed-point format converter among N_REQ requesters.
- Each request carries one signed two's-complement sample in format (N_BITS_IN, BIN_PT_IN).
- Requests are granted round-robin, then rescaled to (N_BITS_OUT, BIN_PT_OUT) with round-half-up and saturation.
- Results are emitted on a single valid/ready stream tagged with the requester index.
- Sits between multiple datapath producers and any consumer needing a common number format.

Parameters:
N_REQ, 4, number of requesters (>=2)
N_BITS_IN, 8, input sample width
BIN_PT_IN, 4, input fractional bits (0..N_BITS_IN)
N_BITS_OUT, 4, output sample width
BIN_PT_OUT, 1, output fractional bits (0..N_BITS_OUT)
ID_W, 2, requester-index width (>= clog2(N_REQ))

Ports:
clk  input  1  clock, all state rising-edge
rst  input  1  asynchronous active-high reset
in_data  input  N_REQ*N_BITS_IN  packed samples, requester i at [i*N_BITS_IN +: N_BITS_IN]
in_valid  input  N_REQ  per-requester valid
in_ready  output  N_REQ  per-requester ready; at most one bit high
out_data  output  N_BITS_OUT  converted sample
out_id  output  ID_W  index of the originating requester
out_ovf  output  1  sample was saturated
out_valid  output  1  result valid
out_ready  input  1  consumer ready

Behaviour:
- Handshake:
  - A transfer occurs on an edge where valid && ready.
  - Requesters hold data and valid stable until the transfer.
  - in_ready never depends combinationally on out_ready except through stage-advance logic.
- Arbitration:
  - Round-robin pointer ptr, reset 0.
  - Grant goes to the first i with in_valid[i] high, searching from ptr upward and wrapping modulo N_REQ.
  - in_ready[g] = grant && s1_adv; all other bits are 0.
  - After a transfer from requester g, ptr <= (g+1) mod N_REQ.
  - With no transfer, ptr holds.
- Pipeline (two register stages):
  - S1 captures the aligned and rounded value at width N_BITS_IN+|BIN_PT_OUT-BIN_PT_IN|+1, plus the id.
  - S2 captures the saturated result, ovf and id; S2 drives the out_* ports.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - Bubbles collapse.
  - Throughput is one sample per cycle with continuous out_ready.
  - Latency from input transfer edge to out_valid high is 2 cycles.
- Alignment and rounding, with d = BIN_PT_IN - BIN_PT_OUT:
  - d > 0: sign-extend by 1 bit, add 2^(d-1), arithmetic shift right by d (floor). Ties round toward +inf.
  - d <= 0: sign-extend, shift left by -d. Exact, no rounding.
- Saturation:
  - If the S1 value exceeds 2^(N_BITS_OUT-1)-1, output that maximum with ovf=1.
  - If it is below -2^(N_BITS_OUT-1), output that minimum with ovf=1.
  - Otherwise output the low N_BITS_OUT bits with ovf=0.
- Backpressure:
  - With out_ready low and S2 valid, S2 holds all out_* stable.
  - S1 accepts one more sample if empty, then in_ready goes all-zero.
- Reset (asynchronous, effective immediately):
  - Clears s1_valid, s2_valid and ptr to 0.
  - out_valid=0, out_data=0, out_id=0, out_ovf=0, in_ready=0 while rst is high.
  - Reset asserted mid-operation discards in-flight samples; nothing is emitted for them.
- Simultaneous events:
  - Input acceptance and output drain in the same cycle are both honoured.
  - A requester that deasserts valid before being granted is skipped without changing ptr.

Test Plan:
- Single request, defaults: req0 sends 8'h16 (1.375); out_ready=1 → two cycles later out_data=4'b0011 (1.5), out_id=0, out_ovf=0.
- Rounding tie: req1 sends 8'hFC (-0.25) → out_data=4'b0000, ovf=0. Then 8'h0C (0.75) → out_data=4'b0010 (1.0).
- Saturation:
  - 8'h7F → out_data=4'b0111, ovf=1.
  - 8'h80 → out_data=4'b1000, ovf=1.
  - 8'h30 (3.0) → out_data=4'b0110, ovf=0.
- Round-robin: all four requesters hold valid continuously with out_ready=1 → out_id sequence 0,1,2,3,0,1…, one result per cycle after a 2-cycle fill. Only one in_ready bit is high per cycle.
- Backpressure: stream from req2 with out_ready=0 for 5 cycles → out_* stable, exactly 2 samples buffered, then in_ready=0. Release out_ready → samples emerge in order with no loss or duplication.
- Reset mid-stream: assert rst with both stages valid → out_valid drops immediately, ptr=0. After release, the first grant goes to the lowest valid index ≥ 0.
